puf_lfsr_checker: RTL

Receive-side companion to the PUF challenge LFSR. It accepts a stream of WIDTH-bit challenge words, self-synchronises to the XNOR-feedback LFSR sequence, and then predicts every following word. It reports lock status, per-word match results, saturating error and word counters, and the measured sequence period. It sits between the challenge path and the PUF response logic, for bring-up and integrity checking of challenge delivery.

---
 rtl/puf_lfsr_checker.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/puf_lfsr_checker.sv
// Receive-side checker for the XNOR-feedback PUF challenge LFSR: self-synchronises to the
// incoming word stream, flags per-word prediction results and tracks error/word/period stats.
module puf_lfsr_checker #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_stats,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             locked,
    output logic             chk_valid,
    output logic             chk_match,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len
);

    localparam int unsigned McntW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MissW = $clog2(UNLOCK_CNT + 1);

    // Tap masks in 0-indexed bit positions (tap t -> bit t-1).
    function automatic logic [31:0] tap_mask(input int unsigned w);
        logic [31:0] m;
        case (w)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    localparam logic [WIDTH-1:0] Taps = WIDTH'(tap_mask(WIDTH));

    // Every tap set has an even count, so XNOR feedback maps all-ones onto itself.
    function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] x);
        logic fb;
        fb = ~^(x & Taps);
        return {x[WIDTH-2:0], fb};
    endfunction

    typedef enum logic [1:0] {
        StHunt,
        StVerify,
        StLocked
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pred_q, pred_d;
    logic [WIDTH-1:0]   ref_word_q, ref_word_d;
    logic [McntW-1:0]   mcnt_q, mcnt_d;
    logic [MissW-1:0]   miss_q, miss_d;
    logic [WIDTH-1:0]   pos_q, pos_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic               locked_q;
    logic               chk_valid_q, chk_valid_d;
    logic               chk_match_q, chk_match_d;
    logic               period_done_q, period_done_d;
    logic [WIDTH-1:0]   period_len_q, period_len_d;

    logic               match;
    logic               is_ones;
    logic [McntW-1:0]   mcnt_inc;
    logic [MissW-1:0]   miss_inc;
    logic [WIDTH-1:0]   pos_inc;
    logic [WIDTH-1:0]   pred_next;
    logic [WIDTH-1:0]   seed_next;

    assign match     = (data_in == pred_q);
    assign is_ones   = &data_in;
    assign mcnt_inc  = mcnt_q + 1'b1;
    assign miss_inc  = miss_q + 1'b1;
    assign pos_inc   = pos_q + 1'b1;
    assign pred_next = next_word(pred_q);
    assign seed_next = next_word(data_in);

    always_comb begin
        state_d       = state_q;
        pred_d        = pred_q;
        ref_word_d    = ref_word_q;
        mcnt_d        = mcnt_q;
        miss_d        = miss_q;
        pos_d         = pos_q;
        err_d         = err_q;
        wcnt_d        = wcnt_q;
        chk_valid_d   = 1'b0;
        chk_match_d   = chk_match_q;
        period_done_d = 1'b0;
        period_len_d  = period_len_q;

        if (data_valid) begin
            unique case (state_q)
                StHunt: begin
                    // The lockup word carries no sequence information.
                    if (!is_ones) begin
                        ref_word_d = data_in;
                        pred_d     = seed_next;
                        pos_d      = '0;
                        mcnt_d     = '0;
                        state_d    = StVerify;
                    end
                end
                StVerify: begin
                    chk_valid_d = 1'b1;
                    chk_match_d = match;
                    if (match) begin
                        pred_d = pred_next;
                        pos_d  = pos_inc;
                        mcnt_d = mcnt_inc;
                        if (mcnt_inc == McntW'(LOCK_CNT)) begin
                            state_d = StLocked;
                            miss_d  = '0;
                        end
                    end else if (is_ones) begin
                        state_d = StHunt;
                    end else begin
                        ref_word_d = data_in;
                        pred_d     = seed_next;
                        pos_d      = '0;
                        mcnt_d     = '0;
                    end
                end
                StLocked: begin
                    chk_valid_d = 1'b1;
                    chk_match_d = match;
                    // Flywheel: keep predicting through isolated errors.
                    pred_d      = pred_next;
                    if (!(&wcnt_q)) begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                    if (!match) begin
                        if (!(&err_q)) begin
                            err_d = err_q + 1'b1;
                        end
                        miss_d = miss_inc;
                        if (miss_inc == MissW'(UNLOCK_CNT)) begin
                            state_d = StHunt;
                        end
                    end else begin
                        miss_d = '0;
                    end
                    if (match && (data_in == ref_word_q)) begin
                        period_done_d = 1'b1;
                        period_len_d  = pos_inc;
                        pos_d         = '0;
                    end else begin
                        pos_d = pos_inc;
                    end
                end
                default: state_d = StHunt;
            endcase
        end

        if (clr_stats) begin
            err_d  = '0;
            wcnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StHunt;
            pred_q        <= '0;
            ref_word_q    <= '0;
            mcnt_q        <= '0;
            miss_q        <= '0;
            pos_q         <= '0;
            err_q         <= '0;
            wcnt_q        <= '0;
            locked_q      <= 1'b0;
            chk_valid_q   <= 1'b0;
            chk_match_q   <= 1'b0;
            period_done_q <= 1'b0;
            period_len_q  <= '0;
        end else begin
            state_q       <= state_d;
            pred_q        <= pred_d;
            ref_word_q    <= ref_word_d;
            mcnt_q        <= mcnt_d;
            miss_q        <= miss_d;
            pos_q         <= pos_d;
            err_q         <= err_d;
            wcnt_q        <= wcnt_d;
            locked_q      <= (state_d == StLocked);
            chk_valid_q   <= chk_valid_d;
            chk_match_q   <= chk_match_d;
            period_done_q <= period_done_d;
            period_len_q  <= period_len_d;
        end
    end

    assign locked      = locked_q;
    assign chk_valid   = chk_valid_q;
    assign chk_match   = chk_match_q;
    assign err_cnt     = err_q;
    assign word_cnt    = wcnt_q;
    assign period_done = period_done_q;
    assign period_len  = period_len_q;

endmodule
